toggle_chain_counter: RTL



---
 rtl/toggle_chain_counter_if.sv | 23 ++
 rtl/toggle_chain_counter.sv | 79 +++++++
 2 files changed

// File: rtl/toggle_chain_counter_if.sv
// Control/status bundle for toggle_chain_counter: count requests in, count and flags out.
interface toggle_chain_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, load, din,
    input  q, qb, tc, ovf
  );

  modport slave (
    input  en, up, load, din,
    output q, qb, tc, ovf
  );
endinterface

// File: rtl/toggle_chain_counter.sv
// Modulo-(MAX+1) up/down counter built from a chain of T-stages, with tc pulse and sticky ovf.
// Define TCC_SATURATE_EN to saturate at the boundaries instead of wrapping.
module toggle_chain_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = (2 ** WIDTH) - 1
) (
  input logic                 clk,
  input logic                 rst,
  toggle_chain_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] q_q,   q_d;
  logic [WIDTH-1:0] qb_q,  qb_d;
  logic             tc_q,  tc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] tog;
  logic             run_ones;
  logic             run_zeros;
  logic             boundary;

  // Per-bit toggle enables: all-ones below for up, all-zeros below for down.
  always_comb begin
    tog       = '0;
    run_ones  = 1'b1;
    run_zeros = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      tog[i]    = bus.en & (bus.up ? run_ones : run_zeros);
      run_ones  = run_ones & q_q[i];
      run_zeros = run_zeros & ~q_q[i];
    end
  end

  assign boundary = bus.en & (bus.up ? (q_q == MAX_V) : (q_q == '0));

  // Next-state: load beats counting; boundary steps override the raw chain.
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (bus.load) begin
      q_d   = (bus.din > MAX_V) ? MAX_V : bus.din;
      ovf_d = 1'b0;
    end else if (boundary) begin
`ifdef TCC_SATURATE_EN
      q_d   = q_q;
`else
      q_d   = bus.up ? '0 : MAX_V;
`endif
      tc_d  = 1'b1;
      ovf_d = 1'b1;
    end else if (bus.en) begin
      q_d   = q_q ^ tog;
    end
    qb_d = ~q_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q   <= '0;
      qb_q  <= '1;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      qb_q  <= qb_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.qb  = qb_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule
